mvu_cmd_scheduler: RTL and testbench

Job scheduler that launches MVU commands over the APB configuration bus. Upstream control logic pushes job descriptors (target MVU, countdown, multiply mode, max-pool enable) into an in-order queue. The block issues each job as a CSR_MVUCOMMAND write to the target MVU once that MVU is idle, and tracks per-MVU busy state from the MVUs' completion pulses. It sits between the job-issue logic and the APB slave port of the MVU array.

---
 rtl/mvu_cmd_scheduler.sv | 158 +++++++++++++++
 tb/tb_mvu_cmd_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvu_cmd_scheduler.sv
// In-order MVU job scheduler: queues job descriptors and issues each one as an
// APB write of the MVU command CSR once the target MVU is idle.
package mvu_pkg;
    localparam int          BMVUA          = 3;
    localparam logic [11:0] CSR_MVUCOMMAND = 12'h040;
endpackage

module mvu_cmd_scheduler #(
    parameter int          NMVU           = 8,
    parameter int          BMVUA          = mvu_pkg::BMVUA,
    parameter int          APB_ADDR_WIDTH = BMVUA + 12,
    parameter int          QDEPTH         = 4,
    parameter int          BCNTDWN        = 29,
    parameter logic [11:0] CMD_OFFSET     = mvu_pkg::CSR_MVUCOMMAND
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [BMVUA-1:0]           job_mvu,
    input  logic [BCNTDWN-1:0]         job_countdown,
    input  logic [1:0]                 job_mulmode,
    input  logic                       job_maxen,
    input  logic [NMVU-1:0]            mvu_done,
    output logic                       apb_psel,
    output logic                       apb_penable,
    output logic                       apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]  apb_paddr,
    output logic [31:0]                apb_pwdata,
    input  logic                       apb_pready,
    output logic [NMVU-1:0]            busy,
    output logic [$clog2(QDEPTH):0]    qcount,
    output logic [15:0]                jobs_issued,
    output logic                       spurious_done,
    output logic                       all_idle
);
    localparam int PW = $clog2(QDEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t             state;
    logic [BMVUA-1:0]   q_mvu  [QDEPTH];
    logic [BCNTDWN-1:0] q_cnt  [QDEPTH];
    logic [1:0]         q_mul  [QDEPTH];
    logic               q_max  [QDEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [BMVUA-1:0]   cur_mvu;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               launch;
    logic               spurious_hit;
    logic [NMVU-1:0]    busy_next;
    logic [31:0]        head_word;

    assign full      = (qcount == (PW+1)'(QDEPTH));
    assign empty     = (qcount == '0);
    assign job_ready = !full && !rst;
    assign push      = job_valid && job_ready;
    assign pop       = (state == ACCESS) && apb_pready;
    assign launch    = (state == IDLE) && !empty && !busy[q_mvu[rd_ptr]];
    assign all_idle  = empty && (busy == '0) && (state == IDLE);

    always_comb begin
        head_word                = '0;
        head_word[BCNTDWN-1:0]   = q_cnt[rd_ptr];
        head_word[29]            = q_max[rd_ptr];
        head_word[31:30]         = q_mul[rd_ptr];
    end

    // Issue sets the bit after completions clear, so a same-MVU collision leaves it busy.
    always_comb begin
        busy_next = busy & ~mvu_done;
        if (pop) begin
            busy_next[cur_mvu] = 1'b1;
        end
    end

    assign spurious_hit = (|(mvu_done & ~busy)) || (pop && mvu_done[cur_mvu]);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mvu[wr_ptr] <= job_mvu;
            q_cnt[wr_ptr] <= job_countdown;
            q_mul[wr_ptr] <= job_mulmode;
            q_max[wr_ptr] <= job_maxen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            qcount        <= '0;
            busy          <= '0;
            jobs_issued   <= '0;
            spurious_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                jobs_issued <= jobs_issued + 16'd1;
            end
            case ({push, pop})
                2'b10:   qcount <= qcount + 1'b1;
                2'b01:   qcount <= qcount - 1'b1;
                default: qcount <= qcount;
            endcase
            busy <= busy_next;
            if (spurious_hit) begin
                spurious_done <= 1'b1;
            end
        end
    end

    // APB master; address and data stay latched from launch until the next launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            cur_mvu     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state      <= SETUP;
                        apb_psel   <= 1'b1;
                        apb_pwrite <= 1'b1;
                        apb_paddr  <= {q_mvu[rd_ptr], CMD_OFFSET};
                        apb_pwdata <= head_word;
                        cur_mvu    <= q_mvu[rd_ptr];
                    end
                end
                SETUP: begin
                    state       <= ACCESS;
                    apb_penable <= 1'b1;
                end
                ACCESS: begin
                    if (apb_pready) begin
                        state       <= IDLE;
                        apb_psel    <= 1'b0;
                        apb_penable <= 1'b0;
                        apb_pwrite  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvu_cmd_scheduler.sv
// Self-checking bench for mvu_cmd_scheduler: transaction-level model plus
// directed scenarios with hand-computed expectations.
module tb_mvu_cmd_scheduler;
    localparam int NMVU   = 8;
    localparam int QDEPTH = 4;

    typedef struct {
        logic [2:0]  mvu;
        logic [28:0] cnt;
        logic [1:0]  mul;
        logic        max;
    } job_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [2:0]  job_mvu = '0;
    logic [28:0] job_countdown = '0;
    logic [1:0]  job_mulmode = '0;
    logic        job_maxen = 1'b0;
    logic [7:0]  mvu_done = '0;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [14:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic        apb_pready = 1'b1;
    logic [7:0]  busy;
    logic [2:0]  qcount;
    logic [15:0] jobs_issued;
    logic        spurious_done;
    logic        all_idle;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    // Model state: pending jobs in order, busy flags, and the write on the bus.
    job_t        mq[$];
    logic [7:0]  m_busy = '0;
    logic        m_active = 1'b0;
    logic        m_second = 1'b0;
    logic [2:0]  m_mvu = '0;
    logic [14:0] m_addr = '0;
    logic [31:0] m_data = '0;
    logic [15:0] m_issued = '0;
    logic        m_spur = 1'b0;

    mvu_cmd_scheduler dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready), .job_mvu(job_mvu),
        .job_countdown(job_countdown), .job_mulmode(job_mulmode), .job_maxen(job_maxen),
        .mvu_done(mvu_done),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pready(apb_pready),
        .busy(busy), .qcount(qcount), .jobs_issued(jobs_issued),
        .spurious_done(spurious_done), .all_idle(all_idle)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // A write launches when the head MVU is idle, takes one setup and at least
    // one access cycle, and completes on the first access cycle with pready.
    always @(posedge clk) begin : model
        logic [7:0] nb;
        logic       can_push;
        if (rst) begin
            mq.delete();
            m_busy   = '0;
            m_active = 1'b0;
            m_second = 1'b0;
            m_issued = '0;
            m_spur   = 1'b0;
        end else begin
            can_push = job_valid && (mq.size() < QDEPTH);
            nb = m_busy;
            for (int i = 0; i < NMVU; i++) begin
                if (mvu_done[i]) begin
                    if (!m_busy[i]) m_spur = 1'b1;
                    nb[i] = 1'b0;
                end
            end
            if (m_active && m_second && apb_pready) begin
                nb[m_mvu] = 1'b1;
                if (mvu_done[m_mvu]) m_spur = 1'b1;
                m_issued = m_issued + 16'd1;
                void'(mq.pop_front());
                m_active = 1'b0;
                m_second = 1'b0;
            end else if (m_active) begin
                m_second = 1'b1;
            end else if (mq.size() != 0 && !m_busy[mq[0].mvu]) begin
                m_active = 1'b1;
                m_second = 1'b0;
                m_mvu    = mq[0].mvu;
                m_addr   = {mq[0].mvu, mvu_pkg::CSR_MVUCOMMAND};
                m_data   = {mq[0].mul, mq[0].max, mq[0].cnt};
            end
            if (can_push) mq.push_back('{job_mvu, job_countdown, job_mulmode, job_maxen});
            m_busy = nb;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("psel", apb_psel, m_active);
            check_output("penable", apb_penable, m_active && m_second);
            check_output("pwrite", apb_pwrite, m_active);
            if (m_active) begin
                check_output("paddr", apb_paddr, m_addr);
                check_output("pwdata", apb_pwdata, m_data);
            end
            check_output("busy", busy, m_busy);
            check_output("qcount", qcount, mq.size());
            check_output("jobs_issued", jobs_issued, m_issued);
            check_output("spurious_done", spurious_done, m_spur);
            check_output("all_idle", all_idle, (mq.size() == 0) && (m_busy == 0) && !m_active);
            check_output("job_ready", job_ready, !rst && (mq.size() < QDEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] mvu, input logic [28:0] cnt,
                                  input logic [1:0] mul, input logic max);
        int guard = 0;
        while (!job_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_output("push_wait_timeout", guard < 50, 1);
        job_mvu = mvu; job_countdown = cnt; job_mulmode = mul; job_maxen = max;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic pulse_done(input logic [7:0] mask);
        mvu_done = mask;
        tick();
        mvu_done = '0;
    endtask

    task automatic drain();
        int guard = 0;
        while (!all_idle && guard < 300) begin
            if (busy != 0) pulse_done(busy);
            else tick();
            guard++;
        end
        check_output("drain_timeout", all_idle, 1);
    endtask

    initial begin
        int guard;
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;
        $display("[TB] starting");
        tick();
        cmp_en = 1'b1;
        tick();
        check_output("reset_job_ready", job_ready, 0);
        check_output("reset_all_idle", all_idle, 1);
        check_output("reset_qcount", qcount, 0);
        rst = 1'b0;
        tick();

        // Single job, cycle-exact timing from acceptance.
        apply_stimulus(3'd2, 29'd100, 2'd1, 1'b1);
        check_output("t1_qcount_n1", qcount, 1);
        tick();
        check_output("t1_psel_n2", apb_psel, 1);
        check_output("t1_penable_n2", apb_penable, 0);
        check_output("t1_paddr", apb_paddr, 15'h2040);
        check_output("t1_pwdata", apb_pwdata, 32'h6000_0064);
        tick();
        check_output("t1_penable_n3", apb_penable, 1);
        tick();
        check_output("t1_busy_n4", busy, 8'h04);
        check_output("t1_issued", jobs_issued, 1);
        check_output("t1_qcount_n4", qcount, 0);
        pulse_done(8'h04);
        check_output("t1_busy_clear", busy, 8'h00);

        // Wait states hold the transfer.
        apb_pready = 1'b0;
        apply_stimulus(3'd4, 29'h1ABCDEF, 2'd2, 1'b0);
        tick();
        tick();
        repeat (3) tick();
        check_output("ws_psel", apb_psel, 1);
        check_output("ws_penable", apb_penable, 1);
        check_output("ws_pwdata", apb_pwdata, 32'h81AB_CDEF);
        check_output("ws_qcount", qcount, 1);
        apb_pready = 1'b1;
        tick();
        check_output("ws_busy", busy, 8'h10);
        check_output("ws_issued", jobs_issued, 2);
        pulse_done(8'h10);

        // Head-of-line blocking.
        apply_stimulus(3'd1, 29'd10, 2'd0, 1'b0);
        apply_stimulus(3'd1, 29'd20, 2'd1, 1'b0);
        apply_stimulus(3'd3, 29'd30, 2'd2, 1'b1);
        repeat (8) tick();
        check_output("hol_busy", busy, 8'h02);
        check_output("hol_qcount", qcount, 2);
        check_output("hol_psel", apb_psel, 0);
        pulse_done(8'h02);
        check_output("hol_busy_fall", busy, 8'h00);
        tick();
        check_output("hol_psel_d2", apb_psel, 1);
        check_output("hol_paddr_d2", apb_paddr, 15'h1040);
        guard = 0;
        while (!(qcount == 0 && busy == 8'h0A) && guard < 20) begin
            tick();
            guard++;
        end
        check_output("hol_both_busy", busy, 8'h0A);
        pulse_done(8'h0A);

        // Full queue behind a busy MVU.
        apply_stimulus(3'd6, 29'd5, 2'd3, 1'b0);
        guard = 0;
        while (!busy[6] && guard < 10) begin
            tick();
            guard++;
        end
        for (int i = 0; i < QDEPTH; i++) apply_stimulus(3'd6, 29'(i + 1), 2'd0, 1'b1);
        check_output("full_qcount", qcount, QDEPTH);
        check_output("full_ready", job_ready, 0);
        pulse_done(8'h40);
        guard = 0;
        while (qcount != 3 && guard < 10) begin
            tick();
            guard++;
        end
        check_output("full_pop_qcount", qcount, 3);
        check_output("full_pop_ready", job_ready, 1);
        drain();

        // Back-to-back jobs to idle MVUs, checked by the model.
        apply_stimulus(3'd0, 29'd7, 2'd1, 1'b0);
        apply_stimulus(3'd5, 29'd8, 2'd2, 1'b1);
        apply_stimulus(3'd7, 29'h1FFFFFFF, 2'd3, 1'b1);
        repeat (10) tick();
        check_output("b2b_busy", busy, 8'hA1);
        drain();

        // Spurious completion.
        pulse_done(8'h20);
        check_output("spur_flag", spurious_done, 1);
        check_output("spur_busy", busy, 8'h00);
        repeat (3) tick();
        check_output("spur_sticky", spurious_done, 1);

        // Reset in the middle of an access.
        apb_pready = 1'b0;
        apply_stimulus(3'd7, 29'd99, 2'd1, 1'b1);
        apply_stimulus(3'd0, 29'd98, 2'd0, 1'b0);
        guard = 0;
        while (!apb_penable && guard < 10) begin
            tick();
            guard++;
        end
        check_output("rst_mid_penable", apb_penable, 1);
        rst = 1'b1;
        tick();
        check_output("rst_mid_psel", apb_psel, 0);
        check_output("rst_mid_qcount", qcount, 0);
        check_output("rst_mid_busy", busy, 8'h00);
        rst = 1'b0;
        apb_pready = 1'b1;
        tick();
        check_output("rst_mid_all_idle", all_idle, 1);
        check_output("rst_mid_spur", spurious_done, 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
